slp_train: RTL and testbench

SLP_TRAIN -- requirements
Module: slp_train

---
 rtl/slp_train_pkg.sv | 37 +++
 rtl/p_sat_add.sv | 48 ++++
 rtl/slp_train.sv | 185 ++++++++++++++++++
 tb/tb_slp_train.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slp_train_pkg.sv
// ---------------------------------------------------------------------------
// slp_train_pkg
// Shared types for the single-layer perceptron trainer:
//   dtype_t       - number format of a data stream (plain integer or fixed point)
//   dconf_t       - format descriptor: dtype, signedness, total bits, fraction bits
//   train_state_t - trainer control states
//   DEF_DCONF_C   - default format (signed 8-bit integer), also reachable through
//                   the `DEF_DCONF macro for parameter defaults
// ---------------------------------------------------------------------------
package slp_train_pkg;

    typedef enum logic {
        INT = 1'b0,
        FXP = 1'b1
    } dtype_t;

    typedef struct packed {
        dtype_t     dtype;
        logic       sgn;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;

    localparam dconf_t DEF_DCONF_C = '{dtype: INT, sgn: 1'b1, prec: 8'd8, frac: 8'd0};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } train_state_t;

endpackage

`ifndef DEF_DCONF
`define DEF_DCONF slp_train_pkg::DEF_DCONF_C
`endif

// File: rtl/p_sat_add.sv
// ---------------------------------------------------------------------------
// p_sat_add
// Signed add/subtract of a W-bit weight and a (W+1)-bit operand, clamped to the
// weight range.
//   a       : current weight (W bits, signed)
//   b       : update operand (W+1 bits, signed)
//   sub     : 1 = a - b, 0 = a + b
//   sum     : clamped result (W bits)
//   clamped : high when the true result was outside the weight range
// ---------------------------------------------------------------------------
module p_sat_add
    import slp_train_pkg::*;
#(
    parameter dconf_t W_CONF = `DEF_DCONF,
    localparam int    W      = int'(W_CONF.prec)
) (
    input  logic [W-1:0] a,
    input  logic [W:0]   b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         clamped
);

    // Two guard bits cover the widest case: a W-bit value minus a (W+1)-bit one.
    localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

    logic signed [W+1:0] a_ext;
    logic signed [W+1:0] b_ext;
    logic signed [W+1:0] full;

    // Compute the exact result, then pin it to the nearest representable weight.
    always_comb begin
        a_ext   = (W+2)'($signed(a));
        b_ext   = (W+2)'($signed(b));
        full    = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        sum     = full[W-1:0];
        clamped = 1'b0;
        if (full > MAX_V) begin
            sum     = MAX_V[W-1:0];
            clamped = 1'b1;
        end else if (full < MIN_V) begin
            sum     = MIN_V[W-1:0];
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/slp_train.sv
// ---------------------------------------------------------------------------
// slp_train
// Serial perceptron-rule trainer. A sample is latched, the externally computed
// prediction y is compared with the target, and on a mistake every weight
// (bias last) is nudged by +/- its input, one weight per cycle.
//   clk, reset                       : clock, async active-high reset
//   in_valid / in_ready / in / target: sample handshake and payload
//   y                                : prediction from an external slp_infer
//   x_q, weight                      : latched sample and weight registers
//   wload_en / wload_idx / wload_data: direct weight write (IDLE only)
//   clear                            : clears err_cnt and sat
//   done / updated                   : end-of-sample pulse, weights-changed flag
//   err_cnt, sat                     : mistake count, sticky clamp flag
// ---------------------------------------------------------------------------
module slp_train
    import slp_train_pkg::*;
#(
    parameter int     IN       = 8,
    parameter dconf_t I_CONF   = `DEF_DCONF,
    parameter dconf_t W_CONF   = `DEF_DCONF,
    parameter int     LR_SHIFT = 0,
    parameter int     CNT_W    = 16,
    localparam int    WEIGHT   = IN + 1,
    localparam int    I_PREC   = int'(I_CONF.prec),
    localparam int    W_PREC   = int'(W_CONF.prec),
    localparam int    IDX_W    = $clog2(WEIGHT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN*I_PREC-1:0]     in,
    input  logic                     target,
    input  logic                     y,
    output logic [IN*I_PREC-1:0]     x_q,
    output logic [WEIGHT*W_PREC-1:0] weight,
    input  logic                     wload_en,
    input  logic [IDX_W-1:0]         wload_idx,
    input  logic [W_PREC-1:0]        wload_data,
    input  logic                     clear,
    output logic                     done,
    output logic                     updated,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     sat
);

    localparam int OP_W = W_PREC + 1;
    localparam logic signed [I_PREC-1:0] CONST1 =
        (I_CONF.dtype == FXP) ? (I_PREC'(1) << I_CONF.frac) : I_PREC'(1);

    train_state_t state;
    train_state_t state_nxt;

    logic [W_PREC-1:0]        w_reg [WEIGHT];
    logic [IN*I_PREC-1:0]     x_reg;
    logic                     target_q;
    logic [IDX_W-1:0]         idx;
    logic                     err_nz;
    logic                     err_sub;
    logic [CNT_W-1:0]         cnt;
    logic                     sat_reg;

    logic                     accept;
    logic                     mistake;
    logic                     last_idx;
    logic signed [I_PREC-1:0] x_sel;
    logic signed [I_PREC-1:0] x_shift;
    logic [OP_W-1:0]          operand;
    logic [W_PREC-1:0]        w_new;
    logic                     add_clamped;

    assign accept   = (state == IDLE) && !wload_en && in_valid;
    assign mistake  = (target_q != y);
    assign last_idx = (idx == IDX_W'(WEIGHT - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake/status outputs. A pending weight load blocks
    // acceptance so the load wins when both arrive in the same IDLE cycle.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        updated   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !wload_en;
                if (accept) state_nxt = EVAL;
            end
            EVAL:   state_nxt = mistake ? UPDATE : DONE;
            UPDATE: if (last_idx) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                updated   = err_nz;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sample latch, error sign and the serial weight index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg    <= '0;
            target_q <= 1'b0;
            idx      <= '0;
            err_nz   <= 1'b0;
            err_sub  <= 1'b0;
        end else begin
            if (accept) begin
                x_reg    <= in;
                target_q <= target;
            end
            if (state == EVAL) begin
                err_nz  <= mistake;
                err_sub <= y;
                idx     <= '0;
            end else if (state == UPDATE) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Pick the input for the current index; the last slot is the bias input.
    always_comb begin
        x_sel = CONST1;
        for (int i = 0; i < IN; i++) begin
            if (idx == IDX_W'(i)) x_sel = x_reg[i*I_PREC +: I_PREC];
        end
    end

    assign x_shift = x_sel >>> LR_SHIFT;
    assign operand = OP_W'(x_shift);

    // err is only ever +/-1, so the update reduces to an add or a subtract.
    p_sat_add #(.W_CONF(W_CONF)) u_sat_add (
        .a       (w_reg[idx]),
        .b       (operand),
        .sub     (err_sub),
        .sum     (w_new),
        .clamped (add_clamped)
    );

    // Weights change only through an IDLE load or the serial update, so they
    // are steady while y settles during EVAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WEIGHT; i++) w_reg[i] <= '0;
        end else if ((state == IDLE) && wload_en) begin
            if (32'(wload_idx) < WEIGHT) w_reg[wload_idx] <= wload_data;
        end else if (state == UPDATE) begin
            w_reg[idx] <= w_new;
        end
    end

    // Mistake counter and clamp flag; clear beats a same-cycle increment/set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            sat_reg <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            sat_reg <= 1'b0;
        end else begin
            if ((state == EVAL) && mistake && (cnt != '1)) cnt <= cnt + 1'b1;
            if ((state == UPDATE) && add_clamped) sat_reg <= 1'b1;
        end
    end

    for (genvar g = 0; g < WEIGHT; g++) begin : g_wflat
        assign weight[g*W_PREC +: W_PREC] = w_reg[g];
    end

    assign x_q     = x_reg;
    assign err_cnt = cnt;
    assign sat     = sat_reg;

endmodule

// File: tb/tb_slp_train.sv
// ---------------------------------------------------------------------------
// tb_slp_train
// Self-checking bench for slp_train with IN=2, signed 8-bit integer formats
// and unit learning rate. A plain integer perceptron-rule model tracks the
// expected weights, mistake count and clamp flag.
// ---------------------------------------------------------------------------
module tb_slp_train;
    import slp_train_pkg::*;

    localparam int IN     = 2;
    localparam int WEIGHT = IN + 1;
    localparam int P      = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN*P-1:0]      in_vec;
    logic                 target;
    logic                 y;
    logic [IN*P-1:0]      x_q;
    logic [WEIGHT*P-1:0]  weight;
    logic                 wload_en;
    logic [1:0]           wload_idx;
    logic [P-1:0]         wload_data;
    logic                 clear;
    logic                 done;
    logic                 updated;
    logic [15:0]          err_cnt;
    logic                 sat;

    int errors = 0;
    int checks = 0;

    int mw [WEIGHT];
    int mcnt;
    bit msat;

    always #5 clk = ~clk;

    slp_train #(
        .IN       (IN),
        .I_CONF   (DEF_DCONF_C),
        .W_CONF   (DEF_DCONF_C),
        .LR_SHIFT (0),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (in_vec),
        .target     (target),
        .y          (y),
        .x_q        (x_q),
        .weight     (weight),
        .wload_en   (wload_en),
        .wload_idx  (wload_idx),
        .wload_data (wload_data),
        .clear      (clear),
        .done       (done),
        .updated    (updated),
        .err_cnt    (err_cnt),
        .sat        (sat)
    );

    function automatic int w_of(input int i);
        logic [P-1:0] v;
        v = weight[i*P +: P];
        return int'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_vec     = '0;
        target     = 1'b0;
        y          = 1'b0;
        wload_en   = 1'b0;
        wload_idx  = '0;
        wload_data = '0;
        clear      = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < WEIGHT; i++) mw[i] = 0;
        mcnt = 0;
        msat = 0;
    endtask

    task automatic wload(input int i, input int v);
        wload_en   = 1'b1;
        wload_idx  = 2'(i);
        wload_data = 8'(v);
        tick();
        wload_en = 1'b0;
        mw[i]    = v;
    endtask

    // Offer one sample and count cycles from acceptance to the done pulse
    // (-1 when the pulse never comes).
    task automatic send(input int x0, input int x1, input bit tgt, input bit yv,
                        output int lat, output bit upd);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        in_vec   = {8'(x1), 8'(x0)};
        target   = tgt;
        y        = yv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        upd = 1'b0;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
        else upd = updated;
    endtask

    // Perceptron rule on plain integers: w += (target - y) * x, clamped.
    task automatic model_apply(input int x0, input int x1, input bit tgt, input bit yv);
        int xs [WEIGHT];
        int e;
        int v;
        if (tgt == yv) return;
        e = int'(tgt) - int'(yv);
        xs[0] = x0;
        xs[1] = x1;
        xs[2] = 1;
        for (int i = 0; i < WEIGHT; i++) begin
            v = mw[i] + e * xs[i];
            if (v > 127) begin v = 127; msat = 1; end
            if (v < -128) begin v = -128; msat = 1; end
            mw[i] = v;
        end
        if (mcnt < 65535) mcnt++;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < WEIGHT; i++) begin
            checks++;
            if (w_of(i) !== 0) begin
                errors++;
                $display("[TB] FAIL reset_w%0d: got %0d expected 0", i, w_of(i));
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        checks++;
        if (sat !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat: got %b expected 0", sat); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_correct();
        int lat;
        bit upd;
        do_reset();
        send(3, -2, 1'b1, 1'b1, lat, upd);
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL correct_latency: got %0d expected 2", lat); end
        checks++;
        if (upd !== 1'b0) begin errors++; $display("[TB] FAIL correct_updated: got %b expected 0", upd); end
        checks++;
        if (x_q !== 16'hFE03) begin errors++; $display("[TB] FAIL correct_x_q: got %h expected fe03", x_q); end
        for (int i = 0; i < WEIGHT; i++) begin
            checks++;
            if (w_of(i) !== 0) begin
                errors++;
                $display("[TB] FAIL correct_w%0d: got %0d expected 0", i, w_of(i));
            end
        end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL correct_err_cnt: got %0d expected 0", err_cnt); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL correct_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_wrong();
        int lat;
        bit upd;
        do_reset();
        send(3, -2, 1'b1, 1'b0, lat, upd);
        model_apply(3, -2, 1'b1, 1'b0);
        checks++;
        if (lat !== WEIGHT + 2) begin errors++; $display("[TB] FAIL wrong_latency: got %0d expected %0d", lat, WEIGHT + 2); end
        checks++;
        if (upd !== 1'b1) begin errors++; $display("[TB] FAIL wrong_updated: got %b expected 1", upd); end
        for (int i = 0; i < WEIGHT; i++) begin
            checks++;
            if (w_of(i) !== mw[i]) begin
                errors++;
                $display("[TB] FAIL wrong_w%0d: got %0d expected %0d", i, w_of(i), mw[i]);
            end
        end
        checks++;
        if (err_cnt !== 16'd1) begin errors++; $display("[TB] FAIL wrong_err_cnt: got %0d expected 1", err_cnt); end
    endtask

    task automatic test_saturation();
        int lat;
        bit upd;
        do_reset();
        wload(0, 126);
        send(5, 0, 1'b1, 1'b0, lat, upd);
        checks++;
        if (w_of(0) !== 127) begin errors++; $display("[TB] FAIL sat_w0: got %0d expected 127", w_of(0)); end
        checks++;
        if (w_of(2) !== 1) begin errors++; $display("[TB] FAIL sat_bias: got %0d expected 1", w_of(2)); end
        checks++;
        if (sat !== 1'b1) begin errors++; $display("[TB] FAIL sat_flag: got %b expected 1", sat); end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (sat !== 1'b0) begin errors++; $display("[TB] FAIL sat_clear_flag: got %b expected 0", sat); end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL sat_clear_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_busy();
        int lat;
        do_reset();
        in_vec   = {8'd1, 8'd1};
        target   = 1'b1;
        y        = 1'b0;
        in_valid = 1'b1;
        tick();
        in_vec = {8'd3, 8'd2};
        target = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_in_ready: got %b expected 0", in_ready); end
        wload_en   = 1'b1;
        wload_idx  = 2'd0;
        wload_data = 8'd55;
        lat = 2;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== WEIGHT + 2) begin errors++; $display("[TB] FAIL busy_first_latency: got %0d expected %0d", lat, WEIGHT + 2); end
        wload_en = 1'b0;
        y        = 1'b1;
        for (int i = 0; i < WEIGHT; i++) begin
            checks++;
            if (w_of(i) !== 1) begin
                errors++;
                $display("[TB] FAIL busy_w%0d_after_first: got %0d expected 1", i, w_of(i));
            end
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL busy_idle_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (x_q !== 16'h0302) begin errors++; $display("[TB] FAIL busy_second_x_q: got %h expected 0302", x_q); end
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== WEIGHT + 2) begin errors++; $display("[TB] FAIL busy_second_latency: got %0d expected %0d", lat, WEIGHT + 2); end
        checks++;
        if (w_of(0) !== -1 || w_of(1) !== -2 || w_of(2) !== 0) begin
            errors++;
            $display("[TB] FAIL busy_second_weights: got {%0d,%0d,%0d} expected {-1,-2,0}", w_of(0), w_of(1), w_of(2));
        end
        checks++;
        if (err_cnt !== 16'd2) begin errors++; $display("[TB] FAIL busy_err_cnt: got %0d expected 2", err_cnt); end
    endtask

    task automatic test_reset_mid_update();
        int seen;
        do_reset();
        wload(0, 10);
        wload(1, 20);
        wload(2, 30);
        in_vec   = {8'hFE, 8'd3};
        target   = 1'b1;
        y        = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (w_of(0) !== 13) begin errors++; $display("[TB] FAIL midrst_partial_w0: got %0d expected 13", w_of(0)); end
        reset = 1'b1;
        #2;
        for (int i = 0; i < WEIGHT; i++) begin
            checks++;
            if (w_of(i) !== 0) begin
                errors++;
                $display("[TB] FAIL midrst_w%0d: got %0d expected 0", i, w_of(i));
            end
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL midrst_done_pulses: got %0d expected 0", seen); end
        checks++;
        if (w_of(1) !== 0) begin errors++; $display("[TB] FAIL midrst_w1_later: got %0d expected 0", w_of(1)); end
    endtask

    task automatic test_random();
        int lat;
        bit upd;
        int x0;
        int x1;
        bit tgt;
        bit yv;
        do_reset();
        for (int n = 0; n < 25; n++) begin
            x0  = int'($urandom_range(255, 0)) - 128;
            x1  = int'($urandom_range(255, 0)) - 128;
            tgt = 1'($urandom_range(1, 0));
            yv  = 1'($urandom_range(1, 0));
            send(x0, x1, tgt, yv, lat, upd);
            model_apply(x0, x1, tgt, yv);
            checks++;
            if (lat !== ((tgt != yv) ? WEIGHT + 2 : 2)) begin
                errors++;
                $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", n, lat, (tgt != yv) ? WEIGHT + 2 : 2);
            end
            checks++;
            if (upd !== (tgt != yv)) begin errors++; $display("[TB] FAIL rand%0d_updated: got %b expected %b", n, upd, tgt != yv); end
            for (int i = 0; i < WEIGHT; i++) begin
                checks++;
                if (w_of(i) !== mw[i]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_w%0d: got %0d expected %0d", n, i, w_of(i), mw[i]);
                end
            end
            checks++;
            if (int'(err_cnt) !== mcnt) begin errors++; $display("[TB] FAIL rand%0d_err_cnt: got %0d expected %0d", n, err_cnt, mcnt); end
            checks++;
            if (sat !== msat) begin errors++; $display("[TB] FAIL rand%0d_sat: got %b expected %b", n, sat, msat); end
            if (n % 8 == 7) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
                mcnt  = 0;
                msat  = 0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_correct();
        test_wrong();
        test_saturation();
        test_busy();
        test_reset_mid_update();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
